// File: rtl/rv_iommu_pwreq_q_pkg.sv
// rv_iommu_pwreq_q_pkg: shared page-walk request types, stall states and queue defaults
package rv_iommu_pwreq_q_pkg;

    localparam int unsigned PWREQ_Q_DEPTH = 4;

    typedef struct packed {
        logic [19:0] did;
        logic [43:0] iova;
    } pw_req_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_STALLED
    } stall_state_e;

endpackage

// File: rtl/rv_iommu_pwreq_q_fifo_mem.sv
// rv_iommu_fifo_mem: register-array storage with one write port and an asynchronous read port
module rv_iommu_fifo_mem #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Entries are written on accepted pushes only; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rv_iommu_pwreq_q.sv
// rv_iommu_pwreq_q: page-walk request FIFO in front of the walker with ddtp stall/drain handling
module rv_iommu_pwreq_q
    import rv_iommu_pwreq_q_pkg::*;
#(
    parameter int unsigned DEPTH = PWREQ_Q_DEPTH,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  pw_req_t       in_pwreq,
    input  logic          in_irdy,
    output logic          in_trdy,
    output pw_req_t       out_pwreq,
    output logic          out_irdy,
    input  logic          out_trdy,
    input  logic          stall_req_i,
    input  logic          walker_idle_i,
    output logic          idle_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] hwm_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, hwm_q, hwm_d;
    stall_state_e  state_q, state_d;
    logic          full, empty, push, pop;

    assign full     = count_q == CW'(DEPTH);
    assign empty    = count_q == '0;
    assign in_trdy  = !full && state_q == ST_RUN && !stall_req_i;
    assign out_irdy = !empty;
    assign push     = in_irdy && in_trdy;
    assign pop      = out_irdy && out_trdy;
    assign idle_o   = state_q == ST_STALLED;
    assign count_o  = count_q;
    assign hwm_o    = hwm_q;

    rv_iommu_fifo_mem #(
        .W     ($bits(pw_req_t)),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_pwreq),
        .raddr (rd_ptr_q),
        .rdata (out_pwreq)
    );

    // Pointer, occupancy and high-water bookkeeping; pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        hwm_d    = count_d > hwm_q ? count_d : hwm_q;
    end

    // Stall protocol: intake stops on request, idle is reported only once drained and the walker is quiet.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     state_d = stall_req_i ? ST_DRAIN : ST_RUN;
            ST_DRAIN:   state_d = !stall_req_i ? ST_RUN :
                                  (empty && walker_idle_i) ? ST_STALLED : ST_DRAIN;
            ST_STALLED: state_d = stall_req_i ? ST_STALLED : ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // State registers; reset discards queued requests but leaves storage untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
            state_q  <= ST_RUN;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
            state_q  <= state_d;
        end
    end

endmodule

// File: tb/tb_rv_iommu_pwreq_q.sv
// tb_rv_iommu_pwreq_q: directed self-checking bench for the page-walk request queue
module tb_rv_iommu_pwreq_q;
    import rv_iommu_pwreq_q_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    pw_req_t    in_pwreq;
    logic       in_irdy;
    logic       in_trdy;
    pw_req_t    out_pwreq;
    logic       out_irdy;
    logic       out_trdy;
    logic       stall_req_i;
    logic       walker_idle_i;
    logic       idle_o;
    logic [2:0] count_o;
    logic [2:0] hwm_o;

    int checks = 0;
    int passes = 0;

    logic [63:0] pay [6] = '{64'hA000_0000_0000_00A1, 64'hB000_0000_0000_00B2,
                             64'hC000_0000_0000_00C3, 64'hD000_0000_0000_00D4,
                             64'hE000_0000_0000_00E5, 64'hF000_0000_0000_00F6};

    rv_iommu_pwreq_q dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_pwreq      (in_pwreq),
        .in_irdy       (in_irdy),
        .in_trdy       (in_trdy),
        .out_pwreq     (out_pwreq),
        .out_irdy      (out_irdy),
        .out_trdy      (out_trdy),
        .stall_req_i   (stall_req_i),
        .walker_idle_i (walker_idle_i),
        .idle_o        (idle_o),
        .count_o       (count_o),
        .hwm_o         (hwm_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Protocol monitors sampled mid-cycle, away from the active edge.
    logic    hold_q = 1'b0;
    pw_req_t held_q;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (in_irdy && in_trdy) check("no_push_full", 64'(count_o == 3'd4), 64'd0);
            if (out_irdy && out_trdy) check("no_pop_empty", 64'(count_o == 3'd0), 64'd0);
            if (hold_q && out_irdy) check("out_stable", out_pwreq, held_q);
            hold_q <= out_irdy && !out_trdy;
            held_q <= out_pwreq;
        end else begin
            hold_q <= 1'b0;
        end
    end

    initial begin
        rst_n = 1'b0; in_irdy = 1'b0; out_trdy = 1'b0; stall_req_i = 1'b0; walker_idle_i = 1'b0;
        in_pwreq = pay[0];
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_hwm", 64'(hwm_o), 64'd0);
        check("rst_out_irdy", 64'(out_irdy), 64'd0);
        check("rst_idle", 64'(idle_o), 64'd0);
        check("rst_in_trdy", 64'(in_trdy), 64'd1);

        // Fill four back to back, then drain in order.
        for (int i = 0; i < 4; i++) begin
            in_pwreq = pay[i]; in_irdy = 1'b1;
            #1;
            check("fill_trdy", 64'(in_trdy), 64'd1);
            tick();
        end
        in_pwreq = pay[4];
        #1;
        check("full_trdy", 64'(in_trdy), 64'd0);
        check("full_count", 64'(count_o), 64'd4);
        check("full_hwm", 64'(hwm_o), 64'd4);
        in_irdy = 1'b0; out_trdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_irdy", 64'(out_irdy), 64'd1);
            check("drain_order", out_pwreq, pay[i]);
            tick();
        end
        check("drained_count", 64'(count_o), 64'd0);
        check("drained_irdy", 64'(out_irdy), 64'd0);
        check("drained_hwm", 64'(hwm_o), 64'd4);
        out_trdy = 1'b0;

        // No same-cycle bypass.
        in_pwreq = pay[0]; in_irdy = 1'b1;
        #1;
        check("lat_irdy0", 64'(out_irdy), 64'd0);
        tick();
        in_pwreq = pay[1];
        #1;
        check("lat_irdy1", 64'(out_irdy), 64'd1);
        check("lat_payload", out_pwreq, pay[0]);
        check("lat_count", 64'(count_o), 64'd1);
        tick();

        // Simultaneous push/pop at count 2, then pop-only when full.
        check("pp_pre_count", 64'(count_o), 64'd2);
        in_pwreq = pay[2]; out_trdy = 1'b1;
        #1;
        check("pp_trdy", 64'(in_trdy), 64'd1);
        check("pp_head", out_pwreq, pay[0]);
        tick();
        check("pp_count", 64'(count_o), 64'd2);
        check("pp_next", out_pwreq, pay[1]);
        out_trdy = 1'b0;
        in_pwreq = pay[3]; tick();
        in_pwreq = pay[4]; tick();
        check("pf_count4", 64'(count_o), 64'd4);
        in_pwreq = pay[5]; out_trdy = 1'b1;
        #1;
        check("pf_trdy", 64'(in_trdy), 64'd0);
        tick();
        check("pf_count3", 64'(count_o), 64'd3);
        in_irdy = 1'b0;
        for (int i = 2; i < 5; i++) begin
            check("pf_order", out_pwreq, pay[i]);
            tick();
        end
        check("pf_empty", 64'(count_o), 64'd0);
        out_trdy = 1'b0;

        // Stall drain with a busy walker, then quiescence, then release.
        in_irdy = 1'b1;
        in_pwreq = pay[0]; tick();
        in_pwreq = pay[1]; tick();
        in_pwreq = pay[2]; stall_req_i = 1'b1; out_trdy = 1'b1;
        #1;
        check("st_trdy0", 64'(in_trdy), 64'd0);
        in_irdy = 1'b0;
        tick();
        check("st_count1", 64'(count_o), 64'd1);
        check("st_idle_a", 64'(idle_o), 64'd0);
        tick();
        check("st_count0", 64'(count_o), 64'd0);
        check("st_idle_b", 64'(idle_o), 64'd0);
        tick();
        check("st_idle_c", 64'(idle_o), 64'd0);
        walker_idle_i = 1'b1;
        #1;
        check("st_idle_d", 64'(idle_o), 64'd0);
        tick();
        check("st_idle_set", 64'(idle_o), 64'd1);
        stall_req_i = 1'b0;
        #1;
        check("st_rel_trdy0", 64'(in_trdy), 64'd0);
        tick();
        check("st_rel_idle", 64'(idle_o), 64'd0);
        check("st_rel_trdy1", 64'(in_trdy), 64'd1);
        out_trdy = 1'b0; walker_idle_i = 1'b0;

        // Stall aborted during drain.
        in_irdy = 1'b1;
        in_pwreq = pay[3]; tick();
        in_pwreq = pay[4]; tick();
        in_irdy = 1'b0; stall_req_i = 1'b1; out_trdy = 1'b1;
        tick();
        check("ab_count1", 64'(count_o), 64'd1);
        check("ab_idle_a", 64'(idle_o), 64'd0);
        stall_req_i = 1'b0; out_trdy = 1'b0;
        tick();
        check("ab_idle_b", 64'(idle_o), 64'd0);
        check("ab_trdy", 64'(in_trdy), 64'd1);
        check("ab_head", out_pwreq, pay[4]);
        out_trdy = 1'b1;
        tick();
        check("ab_empty", 64'(count_o), 64'd0);
        out_trdy = 1'b0;

        // Reset with three entries queued.
        in_irdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pwreq = pay[i]; tick();
        end
        in_irdy = 1'b0;
        check("mr_count3", 64'(count_o), 64'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mr_count", 64'(count_o), 64'd0);
        check("mr_hwm", 64'(hwm_o), 64'd0);
        check("mr_irdy", 64'(out_irdy), 64'd0);
        check("mr_idle", 64'(idle_o), 64'd0);
        in_pwreq = pay[4]; in_irdy = 1'b1;
        tick();
        in_irdy = 1'b0;
        check("mr_first", out_pwreq, pay[4]);
        check("mr_count1", 64'(count_o), 64'd1);
        check("mr_hwm1", 64'(hwm_o), 64'd1);
        out_trdy = 1'b1;
        tick();
        check("mr_final", 64'(count_o), 64'd0);
        out_trdy = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
